// File: rtl/nw_pkg.sv
// nw_pkg: nucleotide codes, code check and sequence FSM states shared by the aligner blocks
package nw_pkg;
  localparam logic [2:0] NT_G = 3'b001;
  localparam logic [2:0] NT_C = 3'b110;
  localparam logic [2:0] NT_A = 3'b100;
  localparam logic [2:0] NT_T = 3'b011;
  typedef enum logic [1:0] {IDLE, LOAD, READY} seq_state_t;
  function automatic logic is_nt(input logic [2:0] s, input logic [2:0] g, input logic [2:0] c,
                                 input logic [2:0] a, input logic [2:0] t);
    return s == g || s == c || s == a || s == t;
  endfunction
endpackage

// File: rtl/seq_mem.sv
// seq_mem: N x 3 symbol store, one sync write port, one sync read port with clearable output register
module seq_mem #(
  parameter int N  = 128,
  parameter int AW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [2:0]    wd,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] ra,
  output logic [2:0]    rd
);
  logic [2:0] ram [N];
  // array is never reset so contents survive loads and resets
  always_ff @(posedge clk)
    if (we) ram[wa] <= wd;
  // output register: reset/clear to zero, holds when no read is requested
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (re) rd <= clr ? 3'b000 : ram[ra];
endmodule

// File: rtl/seq_ram.sv
// seq_ram: loads a nucleotide sequence via handshake and serves qualified 1-cycle reads
module seq_ram
  import nw_pkg::*;
#(
  parameter int N = 128,
  parameter int Bit = $clog2(N + 1),
  parameter logic [2:0] G = NT_G,
  parameter logic [2:0] C = NT_C,
  parameter logic [2:0] A = NT_A,
  parameter logic [2:0] T = NT_T
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  input  logic [2:0]     sym_in,
  input  logic           sym_valid,
  input  logic           sym_last,
  output logic           sym_ready,
  input  logic           en_dout,
  input  logic [Bit-1:0] addr_dout,
  output logic [2:0]     dout,
  output logic           dout_valid,
  output logic           oob,
  output logic [Bit-1:0] len,
  output logic           loaded,
  output logic           sym_err
);
  localparam int AW = N > 1 ? $clog2(N) : 1;
  localparam logic [Bit-1:0] NL = Bit'(N);
  seq_state_t state;
  logic acc, ok, rd_hit;
  // handshake, code check and read qualification from current state
  always_comb begin
    sym_ready = state == LOAD && len < NL;
    loaded = state == READY;
    acc = sym_valid && sym_ready && !load_start;
    ok = is_nt(sym_in, G, C, A, T);
    rd_hit = state == READY && addr_dout < len;
  end
  // sequence FSM: rst beats load_start, load_start beats the symbol handshake
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      sym_err <= 1'b0;
    end else if (load_start) begin
      state <= LOAD;
      len <= '0;
      sym_err <= 1'b0;
    end else if (acc) begin
      if (ok) len <= len + 1'b1;
      else sym_err <= 1'b1;
      if (sym_last || (ok && len + 1'b1 == NL)) state <= READY;
    end
  // read status flags, valid for one cycle after each request
  always_ff @(posedge clk)
    if (rst) begin
      dout_valid <= 1'b0;
      oob <= 1'b0;
    end else begin
      dout_valid <= en_dout && rd_hit;
      oob <= en_dout && state == READY && !rd_hit;
    end
  seq_mem #(.N(N), .AW(AW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(acc && ok && !rst),
    .wa(len[AW-1:0]),
    .wd(sym_in),
    .re(en_dout),
    .clr(!rd_hit),
    .ra(addr_dout[AW-1:0]),
    .rd(dout)
  );
endmodule

// File: tb/tb_seq_ram.sv
// tb_seq_ram: directed and random stimulus against a cycle-level behavioural model
module tb_seq_ram;
  localparam int N = 5;
  localparam int B = 3;
  logic clk = 1'b0;
  logic rst, load_start, sym_valid, sym_last, en_dout, sym_ready, dout_valid, oob, loaded, sym_err;
  logic [2:0] sym_in, dout;
  logic [B-1:0] addr_dout, len;
  int checks = 0;
  int failures = 0;
  int mem_m[N];
  int m_len = 0, m_dout = 0, m_dv = 0, m_oob = 0;
  bit m_loading = 0, m_loaded = 0, m_err = 0;
  int codes[4] = '{1, 6, 4, 3};
  always #5 clk = ~clk;
  seq_ram #(.N(N)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready), .en_dout(en_dout), .addr_dout(addr_dout),
    .dout(dout), .dout_valid(dout_valid), .oob(oob), .len(len), .loaded(loaded), .sym_err(sym_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit is_code(input int s);
    return s == 1 || s == 6 || s == 4 || s == 3;
  endfunction
  task automatic cyc(input bit r, input bit ls, input bit sv, input int s, input bit l,
                     input bit e, input int a);
    rst = r; load_start = ls; sym_valid = sv; sym_in = 3'(s); sym_last = l;
    en_dout = e; addr_dout = B'(a);
    if (r) begin
      m_dout = 0; m_dv = 0; m_oob = 0;
    end else if (e) begin
      m_dv = (m_loaded && a < m_len) ? 1 : 0;
      m_oob = (m_loaded && a >= m_len) ? 1 : 0;
      m_dout = m_dv ? mem_m[a] : 0;
    end else begin
      m_dv = 0; m_oob = 0;
    end
    if (r) begin
      m_loading = 0; m_loaded = 0; m_len = 0; m_err = 0;
    end else if (ls) begin
      m_loading = 1; m_loaded = 0; m_len = 0; m_err = 0;
    end else if (m_loading && sv && m_len < N) begin
      if (is_code(s)) begin
        mem_m[m_len] = s;
        m_len++;
      end else m_err = 1;
      if (l || m_len == N) begin
        m_loading = 0; m_loaded = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("len", 32'(len), 32'(m_len));
    chk("loaded", 32'(loaded), 32'(m_loaded));
    chk("sym_err", 32'(sym_err), 32'(m_err));
    chk("sym_ready", 32'(sym_ready), 32'(m_loading && m_len < N));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("oob", 32'(oob), 32'(m_oob));
  endtask
  task automatic sym(input int s, input bit l);
    cyc(0, 0, 1, s, l, 0, 0);
  endtask
  task automatic rd(input int a);
    cyc(0, 0, 0, 0, 0, 1, a);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int seqa[5] = '{6, 4, 6, 3, 1};
    int exp_rd[5] = '{3'b110, 3'b100, 3'b110, 3'b011, 3'b001};
    rst = 1; load_start = 0; sym_valid = 0; sym_in = 0; sym_last = 0; en_dout = 0; addr_dout = 0;
    cyc(1, 1, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) sym(seqa[i], i == 4);
    chk("load1_len", 32'(len), 32'd5);
    chk("load1_loaded", 32'(loaded), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd(i);
      chk("load1_rd", 32'(dout), 32'(exp_rd[i]));
    end
    idle();
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) sym(seqa[i], 0);
    sym(1, 1);
    chk("full_len", 32'(len), 32'd5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    sym(4, 0);
    sym(7, 0);
    sym(3, 1);
    chk("err_flag", 32'(sym_err), 32'd1);
    rd(1);
    chk("err_rd1", 32'(dout), 32'd3);
    rd(2);
    chk("err_oob", 32'(oob), 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    sym(6, 0); sym(6, 0); sym(6, 0);
    cyc(0, 1, 1, 4, 1, 0, 0);
    sym(1, 0); sym(1, 1);
    rd(2);
    chk("restart_oob", 32'(oob), 32'd1);
    rd(1);
    chk("restart_rd1", 32'(dout), 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    sym(4, 0); sym(3, 0);
    cyc(1, 0, 1, 6, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("rst_dv", 32'(dout_valid), 32'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("load_rd_oob", 32'(oob), 32'd0);
    for (int i = 0; i < 600; i++) begin
      int s;
      s = $urandom_range(0, 9) < 8 ? codes[$urandom_range(0, 3)] : int'($urandom_range(0, 7));
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1, s,
          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
